// File: rtl/risc8_fetch_pkg.sv
// Shared RISC-8 fetch definitions: two-word opcode match patterns,
// reset PC default, NOP encoding and the pop-size encoding.
package risc8_fetch_pkg;

    // LDS/STS: w[15:10]=100100, w[3:0]=0000
    localparam logic [15:0] LDS_STS_MASK  = 16'hFC0F;
    localparam logic [15:0] LDS_STS_VAL   = 16'h9000;
    // JMP/CALL: w[15:9]=1001010, w[3:1]=11x
    localparam logic [15:0] JMP_CALL_MASK = 16'hFE0C;
    localparam logic [15:0] JMP_CALL_VAL  = 16'h940C;

    localparam int unsigned RESET_PC_DEFAULT = 0;
    localparam logic [15:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        POP_NONE,
        POP_ONE,
        POP_TWO
    } pop_e;

    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & LDS_STS_MASK) == LDS_STS_VAL) ||
               ((w & JMP_CALL_MASK) == JMP_CALL_VAL);
    endfunction

endpackage

// File: rtl/risc8_fetch_if.sv
// Fetch -> decode instruction handshake.
// master: fetch stage (drives instr_*), slave: decoder (drives instr_ready).
interface risc8_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr_opcode;
    logic [15:0]       instr_ext;
    logic              instr_two_word;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output instr_valid,
        output instr_opcode,
        output instr_ext,
        output instr_two_word,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_opcode,
        input  instr_ext,
        input  instr_two_word,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/risc8_fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {address, 16-bit word}.
// Ports: push/push_word/push_addr, pop1/pop2, flush, count, head and head+1.
module risc8_fetch_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 16,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [15:0]       push_word,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop1,
    input  logic              pop2,
    output logic [CW-1:0]     count,
    output logic [15:0]       head_word,
    output logic [ADDR_W-1:0] head_addr,
    output logic [15:0]       head1_word
);
    localparam int W = 16 + ADDR_W;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pop_n;
    logic [W-1:0]  head_ent;
    logic [W-1:0]  head1_ent;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop_n    = pop2 ? CW'(2) : (pop1 ? CW'(1) : CW'(0));

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {push_addr, push_word};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            // Pointers are PW bits wide, so DEPTH being a power of two
            // makes the wrap implicit.
            rd_ptr_d = rd_ptr_q + PW'(pop_n);
            count_d  = count_q + CW'(push) - pop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_ent   = mem_q[rd_ptr_q];
    assign head1_ent  = mem_q[rd_ptr_q + PW'(1)];
    assign count      = count_q;
    assign head_word  = head_ent[15:0];
    assign head_addr  = head_ent[W-1:16];
    assign head1_word = head1_ent[15:0];

endmodule

// File: rtl/risc8_fetch.sv
// RISC-8 instruction fetch stage: PC, read issue, prefetch, two-word
// assembly. Ports: clk/reset, pmem_* read bus, redirect/redirect_pc,
// instr (risc8_fetch_if.master) towards the decoder.
module risc8_fetch
    import risc8_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic              pmem_rd_en,
    output logic [ADDR_W-1:0] pmem_addr,
    input  logic [15:0]       pmem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    risc8_fetch_if.master     instr
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic              inflight_ep_q, inflight_ep_d;
    logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
    logic              epoch_q, epoch_d;

    logic [CW-1:0]     fifo_count;
    logic [15:0]       fifo_head_word;
    logic [ADDR_W-1:0] fifo_head_addr;
    logic [15:0]       fifo_head1_word;

    logic              in_vld;
    logic [CW-1:0]     avail;
    logic [15:0]       w0;
    logic [ADDR_W-1:0] a0;
    logic [15:0]       w1;
    logic              two;
    logic              valid;
    logic              fire;
    logic              rd_en;
    logic              in_taken;
    logic              push;
    pop_e              pop_sel;

    // A returning word is only live if no flush happened since its issue.
    assign in_vld = inflight_q && (inflight_ep_q == epoch_q);
    assign avail  = fifo_count + CW'(in_vld);

    // The returning word acts as a virtual tail entry so an instruction
    // can be presented in the same cycle its last word arrives.
    assign w0  = (fifo_count != '0) ? fifo_head_word : pmem_data;
    assign a0  = (fifo_count != '0) ? fifo_head_addr : inflight_addr_q;
    assign w1  = (fifo_count >= CW'(2)) ? fifo_head1_word : pmem_data;
    assign two = is_two_word(w0);

    assign valid = !reset && (avail >= (two ? CW'(2) : CW'(1)));
    assign fire  = valid && instr.instr_ready;

    always_comb begin
        pop_sel  = POP_NONE;
        in_taken = 1'b0;
        if (fire) begin
            if (two) begin
                if (fifo_count >= CW'(2)) begin
                    pop_sel = POP_TWO;
                end else begin
                    pop_sel  = POP_ONE;
                    in_taken = 1'b1;
                end
            end else if (fifo_count != '0) begin
                pop_sel = POP_ONE;
            end else begin
                in_taken = 1'b1;
            end
        end
    end

    assign push = in_vld && !in_taken && !redirect;

    // Credit includes the in-flight word, so a push always has room.
    assign rd_en = !reset && !redirect &&
                   ((fifo_count + CW'(inflight_q)) < CW'(DEPTH));

    always_comb begin
        pc_d            = pc_q;
        epoch_d         = epoch_q ^ redirect;
        inflight_d      = rd_en;
        inflight_ep_d   = epoch_q;
        inflight_addr_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (rd_en) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= ADDR_W'(RESET_PC);
            epoch_q         <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_ep_q   <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            pc_q            <= pc_d;
            epoch_q         <= epoch_d;
            inflight_q      <= inflight_d;
            inflight_ep_q   <= inflight_ep_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    risc8_fetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_word  (pmem_data),
        .push_addr  (inflight_addr_q),
        .pop1       (pop_sel == POP_ONE),
        .pop2       (pop_sel == POP_TWO),
        .count      (fifo_count),
        .head_word  (fifo_head_word),
        .head_addr  (fifo_head_addr),
        .head1_word (fifo_head1_word)
    );

    assign pmem_rd_en           = rd_en;
    assign pmem_addr            = pc_q;
    assign instr.instr_valid    = valid;
    assign instr.instr_opcode   = valid ? w0 : NOP;
    assign instr.instr_ext      = (valid && two) ? w1 : 16'h0000;
    assign instr.instr_two_word = valid && two;
    assign instr.instr_pc       = valid ? a0 : '0;

endmodule

// File: doc/risc8_fetch.md
Name: risc8_fetch

Overview:
- Instruction fetch stage directly upstream of the RISC-8 instruction decoder.
- Holds the program counter and issues sequential reads to synchronous program memory.
- Buffers returned 16-bit words in a small prefetch FIFO and presents one complete instruction per handshake: opcode, optional second word, and its PC.
- Accepts a redirect (jump/branch/return target) from the execute stage, which flushes all prefetched and in-flight words.

Parameters:
ADDR_W, 16, program-memory word-address width; PC wraps modulo 2^ADDR_W
DEPTH, 4, prefetch FIFO depth in 16-bit words; legal values are powers of two, minimum 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high reset
pmem_rd_en  out  1  program-memory read strobe
pmem_addr  out  ADDR_W  word address for the read
pmem_data  in  16  read data, valid exactly one cycle after pmem_rd_en
redirect  in  1  load new PC and flush
redirect_pc  in  ADDR_W  target word address
instr_valid  out  1  a complete instruction is presented
instr_ready  in  1  decoder accepts the instruction
instr_opcode  out  16  first instruction word, fed to the decoder opcode input
instr_ext  out  16  second word (address/constant); 0 when instr_two_word=0
instr_two_word  out  1  instruction is 32-bit (LDS/STS/JMP/CALL)
instr_pc  out  ADDR_W  address of instr_opcode

Behaviour:
- Reset is synchronous: clock and reset are single-domain, and reset is synchronous and active-high, sampled on rising clk. While reset is high:
  - fetch PC = RESET_PC
  - FIFO empty, in-flight flag = 0
  - pmem_rd_en = 0, instr_valid = 0
  - instr_opcode/instr_ext/instr_pc = 0, instr_two_word = 0
- Read issue:
  - pmem_rd_en = 1 when (fifo_count + inflight) < DEPTH and no redirect this cycle.
  - pmem_addr = fetch PC; the PC increments by 1 on each issue and wraps 2^ADDR_W-1 -> 0.
  - Issue-ahead is allowed: at most one read outstanding per cycle, and one word returns per cycle.
- Read return:
  - The word returning one cycle after an issue is pushed into the FIFO together with its address.
  - If a redirect occurred in the cycle of issue, or the cycle after, that word is discarded (epoch bit compared).
- Two-word detection, on the head word w:
  - (w[15:10]=100100 and w[3:0]=0000): LDS/STS.
  - (w[15:9]=1001010 and w[3:1]=110 or 111): JMP/CALL.
- instr_valid:
  - Single-word instruction: instr_valid = 1 when the FIFO holds >= 1 word.
  - Two-word instruction: instr_valid = 1 only when the FIFO holds >= 2 words.
  - Outputs are driven combinationally from the FIFO head and head+1; no extra latency.
- Handshake:
  - On instr_valid & instr_ready, pop 1 or 2 words.
  - While instr_valid=1 and instr_ready=0, all instr_* outputs hold stable.
- Redirect:
  - Next cycle: fetch PC = redirect_pc, FIFO empty, in-flight word discarded, instr_valid = 0.
  - First new read issues the cycle after redirect; the first instruction is valid 2 cycles after the redirect cycle.
- Simultaneous events:
  - redirect with a handshake: the handshake completes (decoder owns that instruction); the flush still applies.
  - redirect with reset: reset wins.
  - push and pop in the same cycle: the count is adjusted by the net amount.
- Full FIFO: no issue; data is never dropped because credit counts in-flight words.
- Two-word instruction at PC=2^ADDR_W-1: the second word is fetched from address 0.
- Latency after reset release: first read in cycle 1, instr_valid in cycle 2.

Decomposition:
- Shared package/include (alongside the decoder's instruction defines):
  - two-word opcode match masks/values
  - RESET_PC default
  - NOP encoding 16'h0000
- One sub-module: risc8_fetch_fifo, a parameterised DEPTH x (16+ADDR_W) synchronous FIFO.
  - Ports: push, pop1, pop2, flush, count, head and head+1 outputs.
- Top level holds the PC, epoch, issue credit and two-word detection.

Test Plan:
- Reset release, memory holds 0x0C01,0x2C00 at 0,1 -> instr_valid at cycle 2 with opcode 0x0C01, pc 0; then 0x2C00, pc 1; two_word=0.
- JMP 0x940C at addr 4, 0x0123 at addr 5 -> single handshake: opcode 0x940C, ext 0x0123, two_word=1, pc 4; next pc 6.
- instr_ready held 0 for 10 cycles -> outputs stable; pmem_rd_en stops once count+inflight=DEPTH=4; no word lost when ready resumes.
- redirect to 0x0040 while a read to 0x0007 is in flight -> word from 0x0007 never presented; next valid instr has pc 0x0040 exactly 2 cycles later.
- LDS 0x9100 at ADDR_W max 0xFFFF, ext at 0x0000 -> opcode/ext paired correctly across wrap.
- redirect and instr_valid&instr_ready in the same cycle -> current instruction consumed once; FIFO flushed; no duplicate or stale instruction afterward.
